// File: rtl/dpram_rdq_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dpram_rdq_reader : read side of a 64-entry dual-port LUT-RAM queue with  |
// |                    a registered valid/ready output stage.                |
// | Optional level output enabled by defining RDQ_LEVEL_EN.                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module dpram_rdq_reader #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic [6:0]       wptr,
   output logic [5:0]       ra,
   input  logic [WIDTH-1:0] rdata,
   output logic [6:0]       rptr,
   output logic [WIDTH-1:0] dout,
   output logic             dvalid,
   input  logic             dready,
   input  logic             flush,
   output logic             ovf,
   output logic [6:0]       level
);

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [6:0] w_rptr_nxt;
   logic [6:0] w_occ;
   logic       w_avail;
   logic       w_xfer;
   logic       w_load;

   assign w_avail = (wptr != rptr);
   assign w_occ   = wptr - rptr;
   assign w_xfer  = dvalid && dready;
   assign w_load  = w_avail && (!dvalid || dready) && !flush;
   assign dvalid  = (r_state == ST_FULL);
   assign ra      = rptr[5:0];

   // Flush wins over load and transfer; a slot is freed as soon as it loads.
   always_comb begin
      w_state_nxt = r_state;
      w_rptr_nxt  = rptr;
      if (flush) begin
         w_state_nxt = ST_EMPTY;
         w_rptr_nxt  = wptr;
      end else if (w_load) begin
         w_state_nxt = ST_FULL;
         w_rptr_nxt  = rptr + 7'd1;
      end else if (w_xfer) begin
         w_state_nxt = ST_EMPTY;
      end
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         rptr <= 7'd0;
         dout <= '0;
         ovf  <= 1'b0;
      end else begin
         rptr <= w_rptr_nxt;
         if (w_load) begin
            dout <= rdata;
         end
         if (w_occ > 7'd64) begin
            ovf <= 1'b1;
         end
      end
   end

`ifdef RDQ_LEVEL_EN
   logic [6:0] w_level_nxt;

   // Entries still in RAM plus the one held in the output stage.
   assign w_level_nxt = (wptr - w_rptr_nxt) + {6'd0, (w_state_nxt == ST_FULL)};

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         level <= 7'd0;
      end else begin
         level <= w_level_nxt;
      end
   end
`else
   assign level = 7'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dpram_rdq_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dpram_rdq_reader : scoreboard bench for dpram_rdq_reader.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_dpram_rdq_reader;

   localparam int WIDTH = 32;

   logic             CLK = 1'b0;
   logic             Reset = 1'b1;
   logic [6:0]       wptr = 7'd0;
   logic [5:0]       ra;
   logic [WIDTH-1:0] rdata;
   logic [6:0]       rptr;
   logic [WIDTH-1:0] dout;
   logic             dvalid;
   logic             dready = 1'b0;
   logic             flush = 1'b0;
   logic             ovf;
   logic [6:0]       level;

   logic [WIDTH-1:0] mem [64];
   logic [WIDTH-1:0] sb [$];
   int               n_checks = 0;
   int               n_fail = 0;
   int               n_pops = 0;
   logic [WIDTH-1:0] held;

`ifdef RDQ_LEVEL_EN
   localparam bit LVL = 1'b1;
`else
   localparam bit LVL = 1'b0;
`endif

   dpram_rdq_reader #(.WIDTH(WIDTH)) u_dut (
      .CLK    (CLK),
      .Reset  (Reset),
      .wptr   (wptr),
      .ra     (ra),
      .rdata  (rdata),
      .rptr   (rptr),
      .dout   (dout),
      .dvalid (dvalid),
      .dready (dready),
      .flush  (flush),
      .ovf    (ovf),
      .level  (level)
   );

   always #5 CLK = ~CLK;

   assign rdata = mem[ra];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wr(input logic [WIDTH-1:0] d);
      mem[wptr[5:0]] = d;
      wptr = wptr + 7'd1;
      sb.push_back(d);
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      dready = 1'b0;
      flush = 1'b0;
      wptr = 7'd0;
      sb.delete();
      tick();
      Reset = 1'b0;
   endtask

   // Consumer side: every accepted entry must be the oldest one written.
   always @(negedge CLK) begin
      if (!Reset && dvalid && dready) begin
         if (sb.size() == 0) begin
            check("sb_underflow", 64'(sb.size()), 64'd1);
         end else begin
            check("sb_data", 64'(dout), 64'(sb.pop_front()));
            n_pops++;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = '0;

      // Reset values
      tick();
      check("rst_rptr", 64'(rptr), 64'd0);
      check("rst_ra", 64'(ra), 64'd0);
      check("rst_dvalid", 64'(dvalid), 64'd0);
      check("rst_dout", 64'(dout), 64'd0);
      check("rst_ovf", 64'(ovf), 64'd0);
      check("rst_level", 64'(level), 64'd0);
      Reset = 1'b0;

      // Single entry, stalled consumer
      wr(32'hA5A5A5A5);
      tick();
      check("lat_dvalid", 64'(dvalid), 64'd1);
      check("lat_dout", 64'(dout), 64'hA5A5A5A5);
      check("lat_rptr", 64'(rptr), 64'd1);
      check("lat_ra", 64'(ra), 64'd1);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_dout", 64'(dout), 64'hA5A5A5A5);
         check("stall_dvalid", 64'(dvalid), 64'd1);
      end
      dready = 1'b1;
      tick();
      check("drain_dvalid", 64'(dvalid), 64'd0);
      check("drain_pops", 64'(n_pops), 64'd1);

      // Ten back-to-back entries
      do_reset();
      dready = 1'b1;
      n_pops = 0;
      for (int i = 0; i < 10; i++) begin
         wr(32'h1000 + 32'(i));
         tick();
         check("b2b_dvalid", 64'(dvalid), 64'd1);
      end
      tick();
      check("b2b_rptr", 64'(rptr), 64'd10);
      check("b2b_dvalid_end", 64'(dvalid), 64'd0);
      check("b2b_pops", 64'(n_pops), 64'd10);

      // Stream across the 7-bit pointer wrap
      do_reset();
      dready = 1'b1;
      n_pops = 0;
      for (int i = 0; i < 140; i++) begin
         wr($urandom);
         tick();
      end
      tick();
      check("wrap_rptr", 64'(rptr), 64'd12);
      check("wrap_pops", 64'(n_pops), 64'd140);
      check("wrap_sb_left", 64'(sb.size()), 64'd0);

      // Fill to exactly 64 with a stalled consumer, then overrun
      do_reset();
      for (int i = 0; i < 64; i++) begin
         wr(32'h2000 + 32'(i));
         tick();
      end
      tick();
      check("full_rptr", 64'(rptr), 64'd1);
      check("full_dvalid", 64'(dvalid), 64'd1);
      check("full_ovf", 64'(ovf), 64'd0);
      check("full_level", 64'(level), LVL ? 64'd64 : 64'd0);
      wr(32'hDEAD0001);
      tick();
      check("occ64_ovf", 64'(ovf), 64'd0);
      wr(32'hDEAD0002);
      tick();
      check("ovf_set", 64'(ovf), 64'd1);
      sb.delete();
      wptr = 7'd64;
      tick();
      tick();
      check("ovf_sticky", 64'(ovf), 64'd1);

      // Flush with a simultaneous accept
      do_reset();
      for (int i = 0; i < 6; i++) wr(32'h3000 + 32'(i));
      tick();
      tick();
      check("fl_pre_rptr", 64'(rptr), 64'd1);
      check("fl_pre_dvalid", 64'(dvalid), 64'd1);
      held = 32'h3000;
      flush = 1'b1;
      dready = 1'b1;
      tick();
      flush = 1'b0;
      dready = 1'b0;
      sb.delete();
      check("fl_rptr", 64'(rptr), 64'(wptr));
      check("fl_dvalid", 64'(dvalid), 64'd0);
      check("fl_dout", 64'(dout), 64'(held));
      check("fl_level", 64'(level), 64'd0);
      tick();
      check("fl_noload", 64'(dvalid), 64'd0);
      check("fl_rptr_hold", 64'(rptr), 64'd6);

      // Asynchronous reset in the middle of a stream
      do_reset();
      for (int i = 0; i < 4; i++) begin
         wr(32'h4000 + 32'(i));
         tick();
      end
      check("ar_pre_dvalid", 64'(dvalid), 64'd1);
      Reset = 1'b1;
      #2;
      check("ar_rptr", 64'(rptr), 64'd0);
      check("ar_dvalid", 64'(dvalid), 64'd0);
      check("ar_dout", 64'(dout), 64'd0);
      sb.delete();
      tick();
      Reset = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
